// File: rtl/crypt_round_sequencer.sv
// crypt_round_sequencer
// Iterative control FSM for a round-based block encryptor. It whitens the
// incoming block with the cipher key. It then drives an external
// combinational round unit once per cycle for NUM_ROUNDS cycles. The result
// is held until the consumer takes it.
// Optional build macro: CRYPT_BLOCK_COUNT_EN adds blk_count[31:0], a wrapping
// count of ciphertext blocks accepted by the consumer.
module crypt_round_sequencer #(
    parameter int DATA_W     = 128,
    parameter int NUM_ROUNDS = 10,
    parameter int RND_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] plaintext,
    input  logic [DATA_W-1:0] key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ciphertext,
    output logic              done,
    output logic [DATA_W-1:0] rnd_state_o,
    output logic [DATA_W-1:0] rnd_key_o,
    output logic [RND_W-1:0]  rnd_idx,
    output logic              rnd_last,
    input  logic [DATA_W-1:0] rnd_state_i,
    input  logic [DATA_W-1:0] rnd_key_i
`ifdef CRYPT_BLOCK_COUNT_EN
    ,
    output logic [31:0]       blk_count
`endif
);

    localparam logic [RND_W-1:0] FIRST_RND = RND_W'(1);
    localparam logic [RND_W-1:0] LAST_RND  = RND_W'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [DATA_W-1:0] key_q,   key_d;
    logic [RND_W-1:0]  rnd_q,   rnd_d;
    logic              done_q,  done_d;

    logic              accept;
    logic              release_blk;

    // Initial key whitening: full-width XOR of the block with the cipher key.
    function automatic logic [DATA_W-1:0] whiten(input logic [DATA_W-1:0] blk,
                                                 input logic [DATA_W-1:0] k);
        return blk ^ k;
    endfunction

    assign accept      = (state_q == IDLE) && in_valid;
    assign release_blk = (state_q == HOLD) && out_ready;

    // Next-state and datapath-register selection for the three-state sequencer.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = whiten(plaintext, key);
                    key_d   = key;
                    rnd_d   = FIRST_RND;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                // The round unit is combinational: its outputs for the
                // current state/key are committed every cycle, including the
                // final round.
                data_d = rnd_state_i;
                key_d  = rnd_key_i;
                if (rnd_q == LAST_RND) begin
                    // Round index drops to 0 so it never wraps and marks the
                    // round-unit ports as don't-care while holding.
                    rnd_d   = '0;
                    done_d  = 1'b1;
                    state_d = HOLD;
                end else begin
                    rnd_d = rnd_q + FIRST_RND;
                end
            end
            HOLD: begin
                // A new block is only considered once back in IDLE, so the
                // earliest next accept is the cycle after the release.
                if (release_blk) begin
                    rnd_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                rnd_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, data, key and round registers; reset abandons any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            done_q  <= done_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == HOLD);
    assign ciphertext  = out_valid ? data_q : '0;
    assign done        = done_q;
    assign rnd_state_o = data_q;
    assign rnd_key_o   = key_q;
    assign rnd_idx     = rnd_q;
    assign rnd_last    = (rnd_q == LAST_RND);

`ifdef CRYPT_BLOCK_COUNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Count of blocks handed to the consumer; wraps naturally at 32 bits.
    always_comb begin
        cnt_d = cnt_q;
        if (release_blk) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Counter register; an aborted block never reaches HOLD so never counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign blk_count = cnt_q;
`endif

endmodule

// File: tb/tb_crypt_round_sequencer.sv
// Bench for crypt_round_sequencer: two instances with stub round units
// (A: NUM_ROUNDS=10, XOR-with-key rounds, constant key; B: NUM_ROUNDS=3,
// XOR-with-key rounds, key incremented each round).
module tb_crypt_round_sequencer;

    localparam logic [127:0] P0 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] K0 = 128'h12121212121212121212121212121212;
    localparam logic [127:0] C0 = 128'h133157759bb9dffdeccea88a64462002;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_done, a_rnd_last;
    logic [127:0] a_pt, a_key, a_ct, a_rso, a_rko, a_rsi, a_rki;
    logic [3:0]   a_rnd_idx;

    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_done, b_rnd_last;
    logic [127:0] b_pt, b_key, b_ct, b_rso, b_rko, b_rsi, b_rki;
    logic [1:0]   b_rnd_idx;

`ifdef CRYPT_BLOCK_COUNT_EN
    logic [31:0]  a_blk, b_blk;
`endif

    assign a_rsi = a_rso ^ a_rko;
    assign a_rki = a_rko;
    assign b_rsi = b_rso ^ b_rko;
    assign b_rki = b_rko + 128'd1;

    crypt_round_sequencer #(.DATA_W(128), .NUM_ROUNDS(10), .RND_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .plaintext(a_pt), .key(a_key),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .ciphertext(a_ct), .done(a_done),
        .rnd_state_o(a_rso), .rnd_key_o(a_rko),
        .rnd_idx(a_rnd_idx), .rnd_last(a_rnd_last),
        .rnd_state_i(a_rsi), .rnd_key_i(a_rki)
`ifdef CRYPT_BLOCK_COUNT_EN
        , .blk_count(a_blk)
`endif
    );

    crypt_round_sequencer #(.DATA_W(128), .NUM_ROUNDS(3), .RND_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .plaintext(b_pt), .key(b_key),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .ciphertext(b_ct), .done(b_done),
        .rnd_state_o(b_rso), .rnd_key_o(b_rko),
        .rnd_idx(b_rnd_idx), .rnd_last(b_rnd_last),
        .rnd_state_i(b_rsi), .rnd_key_i(b_rki)
`ifdef CRYPT_BLOCK_COUNT_EN
        , .blk_count(b_blk)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference: whitening, then N rounds of s ^= k with the key held constant.
    function automatic logic [127:0] ref_a(input logic [127:0] pt, input logic [127:0] k);
        logic [127:0] s;
        s = pt ^ k;
        for (int r = 1; r <= 10; r++) s = s ^ k;
        return s;
    endfunction

    // Reference: whitening, then 3 rounds of s ^= k, k = k + 1.
    function automatic logic [127:0] ref_b(input logic [127:0] pt, input logic [127:0] k);
        logic [127:0] s;
        logic [127:0] kk;
        s  = pt ^ k;
        kk = k;
        for (int r = 1; r <= 3; r++) begin
            s  = s ^ kk;
            kk = kk + 128'd1;
        end
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stimulus helpers (no checking): offer a pair, wait for the result, release it.
    task automatic a_start(input logic [127:0] pt, input logic [127:0] k);
        @(negedge clk);
        a_in_valid = 1'b1; a_pt = pt; a_key = k;
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_pt = rand128(); a_key = rand128();
    endtask

    task automatic a_wait_out(output int edges);
        edges = 0;
        while (!a_out_valid && edges < 50) begin
            @(posedge clk); #1; edges++;
        end
        if (!a_out_valid) edges = -1;
    endtask

    task automatic a_release();
        @(negedge clk); a_out_ready = 1'b1;
        @(posedge clk); #1; a_out_ready = 1'b0;
    endtask

    task automatic b_start(input logic [127:0] pt, input logic [127:0] k);
        @(negedge clk);
        b_in_valid = 1'b1; b_pt = pt; b_key = k;
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_pt = rand128(); b_key = rand128();
    endtask

    task automatic b_release();
        @(negedge clk); b_out_ready = 1'b1;
        @(posedge clk); #1; b_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 0; a_out_ready = 0; a_pt = '0; a_key = '0;
        b_in_valid = 0; b_out_ready = 0; b_pt = '0; b_key = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", a_in_ready); end
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", a_out_valid); end
        total++; if (a_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", a_done); end
        total++; if (a_ct !== 128'd0) begin bad++; $display("FAIL reset_ciphertext got=%h want=0", a_ct); end
        total++; if (a_rnd_idx !== 4'd0 || a_rnd_last !== 1'b0) begin bad++; $display("FAIL reset_rnd got idx=%0d last=%b want idx=0 last=0", a_rnd_idx, a_rnd_last); end
        total++; if (a_rso !== 128'd0 || a_rko !== 128'd0) begin bad++; $display("FAIL reset_regs got state=%h key=%h want 0", a_rso, a_rko); end
        total++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin bad++; $display("FAIL reset_b got in_ready=%b out_valid=%b want 1/0", b_in_ready, b_out_valid); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        int edges;
        int done_cnt;
        bit idx_ok;
        @(negedge clk);
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL basic_idle_ready got=%b want=1", a_in_ready); end
        a_in_valid = 1'b1; a_pt = P0; a_key = K0;
        @(posedge clk); #1;
        total++; if (a_in_ready !== 1'b0 || a_rnd_idx !== 4'd1) begin bad++; $display("FAIL basic_accept got in_ready=%b idx=%0d want 0/1", a_in_ready, a_rnd_idx); end
        total++; if (a_rso !== (P0 ^ K0) || a_rko !== K0) begin bad++; $display("FAIL basic_whiten got state=%h key=%h want %h/%h", a_rso, a_rko, P0 ^ K0, K0); end
        @(negedge clk); a_in_valid = 1'b0; a_pt = rand128(); a_key = rand128();
        edges = 0; done_cnt = 0; idx_ok = 1'b1;
        while (!a_out_valid && edges < 40) begin
            if (a_rnd_idx !== 4'(edges + 1)) idx_ok = 1'b0;
            if (a_rnd_last !== ((edges + 1) == 10)) idx_ok = 1'b0;
            if (a_done) done_cnt++;
            @(posedge clk); #1; edges++;
        end
        total++; if (edges + 1 != 11) begin bad++; $display("FAIL basic_latency got=%0d edges want=11", edges + 1); end
        total++; if (!idx_ok) begin bad++; $display("FAIL basic_rnd_seq got=bad sequence want=1..10 with last at 10"); end
        total++; if (done_cnt != 0 || a_done !== 1'b1) begin bad++; $display("FAIL basic_done_rise got early=%0d now=%b want 0/1", done_cnt, a_done); end
        total++; if (a_ct !== C0 || a_ct !== ref_a(P0, K0)) begin bad++; $display("FAIL basic_ciphertext got=%h want=%h", a_ct, C0); end
        @(posedge clk); #1;
        total++; if (a_done !== 1'b0 || a_out_valid !== 1'b1) begin bad++; $display("FAIL basic_done_pulse got done=%b out_valid=%b want 0/1", a_done, a_out_valid); end
        @(negedge clk); a_out_ready = 1'b1;
        @(posedge clk); #1; a_out_ready = 1'b0;
        total++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_ct !== 128'd0) begin bad++; $display("FAIL basic_release got out_valid=%b in_ready=%b ct=%h want 0/1/0", a_out_valid, a_in_ready, a_ct); end
    endtask

    task automatic test_hold_stall();
        logic [127:0] pt, k, pt2, k2, exp;
        int edges;
        bit stable;
        pt = rand128(); k = rand128(); exp = ref_a(pt, k);
        a_start(pt, k);
        a_wait_out(edges);
        total++; if (edges != 10 || a_ct !== exp) begin bad++; $display("FAIL stall_first got edges=%0d ct=%h want 10/%h", edges, a_ct, exp); end
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_pt = rand128(); a_key = rand128(); a_out_ready = 1'b0;
            @(posedge clk); #1;
            if (a_out_valid !== 1'b1 || a_ct !== exp || a_done !== 1'b0 || a_in_ready !== 1'b0) stable = 1'b0;
        end
        total++; if (!stable) begin bad++; $display("FAIL stall_hold got=unstable want=stable out_valid/ct, no done, in_ready=0"); end
        pt2 = rand128(); k2 = rand128();
        @(negedge clk); a_out_ready = 1'b1; a_in_valid = 1'b1; a_pt = pt2; a_key = k2;
        @(posedge clk); #1;
        total++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin bad++; $display("FAIL stall_no_same_cycle_accept got out_valid=%b in_ready=%b want 0/1", a_out_valid, a_in_ready); end
        @(negedge clk); a_out_ready = 1'b0;
        @(posedge clk); #1;
        total++; if (a_in_ready !== 1'b0 || a_rnd_idx !== 4'd1) begin bad++; $display("FAIL stall_next_accept got in_ready=%b idx=%0d want 0/1", a_in_ready, a_rnd_idx); end
        a_in_valid = 1'b0; a_pt = rand128(); a_key = rand128();
        a_wait_out(edges);
        total++; if (a_ct !== ref_a(pt2, k2)) begin bad++; $display("FAIL stall_second_ct got=%h want=%h", a_ct, ref_a(pt2, k2)); end
        a_release();
    endtask

    task automatic test_keysched();
        int n;
        logic [1:0] idx_seq [4];
        logic       last_seq [4];
        logic [127:0] key_seq [4];
        b_start(128'd0, 128'd1);
        n = 0;
        while (!b_out_valid && n < 10) begin
            if (n < 4) begin idx_seq[n] = b_rnd_idx; last_seq[n] = b_rnd_last; key_seq[n] = b_rko; end
            @(posedge clk); #1; n++;
        end
        total++; if (n != 3) begin bad++; $display("FAIL ks_latency got=%0d want=3", n); end
        total++; if (idx_seq[0] !== 2'd1 || idx_seq[1] !== 2'd2 || idx_seq[2] !== 2'd3) begin bad++; $display("FAIL ks_idx_seq got=%0d,%0d,%0d want=1,2,3", idx_seq[0], idx_seq[1], idx_seq[2]); end
        total++; if (last_seq[0] !== 1'b0 || last_seq[1] !== 1'b0 || last_seq[2] !== 1'b1) begin bad++; $display("FAIL ks_last_seq got=%b%b%b want=001", last_seq[0], last_seq[1], last_seq[2]); end
        total++; if (key_seq[0] !== 128'd1 || key_seq[1] !== 128'd2 || key_seq[2] !== 128'd3) begin bad++; $display("FAIL ks_key_seq got=%0h,%0h,%0h want=1,2,3", key_seq[0], key_seq[1], key_seq[2]); end
        total++; if (b_ct !== 128'd1 || b_done !== 1'b1) begin bad++; $display("FAIL ks_ciphertext got ct=%h done=%b want 1/1", b_ct, b_done); end
        b_release();
    endtask

    task automatic test_random();
        logic [127:0] pt, k;
        int edges, n;
        for (int it = 0; it < 6; it++) begin
            pt = rand128(); k = rand128();
            a_start(pt, k);
            a_wait_out(edges);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            total++; if (edges != 10 || a_ct !== ref_a(pt, k)) begin bad++; $display("FAIL rand_a[%0d] got edges=%0d ct=%h want 10/%h", it, edges, a_ct, ref_a(pt, k)); end
            a_release();
            pt = rand128(); k = rand128();
            b_start(pt, k);
            n = 0;
            while (!b_out_valid && n < 20) begin @(posedge clk); #1; n++; end
            total++; if (n != 3 || b_ct !== ref_b(pt, k)) begin bad++; $display("FAIL rand_b[%0d] got edges=%0d ct=%h want 3/%h", it, n, b_ct, ref_b(pt, k)); end
            b_release();
        end
    endtask

    task automatic test_abort();
        int n, edges;
        a_start(P0, K0);
        n = 0;
        while (a_rnd_idx !== 4'd5 && n < 20) begin @(posedge clk); #1; n++; end
        total++; if (a_rnd_idx !== 4'd5) begin bad++; $display("FAIL abort_reach_r5 got idx=%0d want=5", a_rnd_idx); end
        @(negedge clk); rst = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_ct !== 128'd0 || a_rnd_idx !== 4'd0 || a_done !== 1'b0) begin
            bad++; $display("FAIL abort_state got in_ready=%b out_valid=%b ct=%h idx=%0d done=%b want 1/0/0/0/0", a_in_ready, a_out_valid, a_ct, a_rnd_idx, a_done);
        end
        @(negedge clk); rst = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        a_start(P0, K0);
        a_wait_out(edges);
        total++; if (edges != 10 || a_ct !== C0) begin bad++; $display("FAIL abort_fresh got edges=%0d ct=%h want 10/%h", edges, a_ct, C0); end
        a_release();
    endtask

    task automatic test_back_to_back();
        logic [127:0] p1, k1, p2, k2;
        int cyc, rises;
        int t [2];
        logic [127:0] cv [2];
        logic prev;
        p1 = rand128(); k1 = rand128(); p2 = rand128(); k2 = rand128();
        @(negedge clk);
        a_in_valid = 1'b1; a_pt = p1; a_key = k1; a_out_ready = 1'b1;
        cyc = 0; rises = 0; prev = 1'b0; t[0] = 0; t[1] = 0; cv[0] = '0; cv[1] = '0;
        while (rises < 2 && cyc < 80) begin
            @(posedge clk); #1; cyc++;
            if (a_out_valid && !prev) begin
                t[rises] = cyc; cv[rises] = a_ct; rises++;
                a_pt = p2; a_key = k2;
                if (rises == 2) a_in_valid = 1'b0;
            end
            prev = a_out_valid;
        end
        a_in_valid = 1'b0;
        @(posedge clk); #1; a_out_ready = 1'b0;
        total++; if (rises != 2 || t[0] != 11) begin bad++; $display("FAIL b2b_first got rises=%0d first=%0d want 2/11", rises, t[0]); end
        total++; if (t[1] - t[0] != 12) begin bad++; $display("FAIL b2b_spacing got=%0d want=12", t[1] - t[0]); end
        total++; if (cv[0] !== ref_a(p1, k1) || cv[1] !== ref_a(p2, k2)) begin bad++; $display("FAIL b2b_ct got=%h,%h want=%h,%h", cv[0], cv[1], ref_a(p1, k1), ref_a(p2, k2)); end
    endtask

`ifdef CRYPT_BLOCK_COUNT_EN
    task automatic test_blk_count();
        int edges, n;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total++; if (a_blk !== 32'd0 || b_blk !== 32'd0) begin bad++; $display("FAIL cnt_reset got=%0d,%0d want=0,0", a_blk, b_blk); end
        @(negedge clk); rst = 1'b0;
        a_start(P0, K0);
        n = 0;
        while (a_rnd_idx !== 4'd4 && n < 20) begin @(posedge clk); #1; n++; end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_start(rand128(), rand128());
            a_wait_out(edges);
            if (i == 0) begin
                total++; if (a_blk !== 32'd0) begin bad++; $display("FAIL cnt_hold got=%0d want=0", a_blk); end
            end
            a_release();
        end
        total++; if (a_blk !== 32'd3) begin bad++; $display("FAIL cnt_three got=%0d want=3", a_blk); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
        total++; if (a_blk !== 32'd0) begin bad++; $display("FAIL cnt_clear got=%0d want=0", a_blk); end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_hold_stall();
        test_keysched();
        test_random();
        test_abort();
        test_back_to_back();
`ifdef CRYPT_BLOCK_COUNT_EN
        test_blk_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crypt_round_sequencer.md
Name: crypt_round_sequencer

Overview:
- Iterative control FSM for the 128-bit round-based encryptor datapath.
- Accepts one plaintext/key pair per transaction over a valid/ready handshake.
- Applies initial key whitening, then drives an external combinational round unit once per cycle for NUM_ROUNDS cycles, including the key-schedule step.
- Holds the ciphertext until the consumer accepts it; the top-level encryptor wrapper instantiates this block next to the round unit.

Parameters:
- DATA_W, 128, width of plaintext, key, state and ciphertext.
- NUM_ROUNDS, 10, number of round-unit iterations per block; legal range 1..15.
- RND_W, 4, width of the round index; must satisfy 2^RND_W > NUM_ROUNDS.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  plaintext/key pair offered.
- in_ready  output  1  block can accept a pair.
- plaintext  input  DATA_W  block to encrypt.
- key  input  DATA_W  cipher key.
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  consumer accepts ciphertext.
- ciphertext  output  DATA_W  result; zero unless out_valid.
- done  output  1  one-cycle pulse on the cycle out_valid first rises.
- rnd_state_o  output  DATA_W  current state to the round unit.
- rnd_key_o  output  DATA_W  current round key to the round unit.
- rnd_idx  output  RND_W  current round number, 1..NUM_ROUNDS.
- rnd_last  output  1  high when rnd_idx == NUM_ROUNDS (final round, e.g. no column mix).
- rnd_state_i  input  DATA_W  round-unit output state.
- rnd_key_i  input  DATA_W  round-unit next round key.

Behaviour:
- Reset:
  - clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
  - At reset, and on the cycle after any rst-high edge: state=IDLE, in_ready=1, out_valid=0, done=0, ciphertext=0, rnd_idx=0, rnd_last=0.
  - The internal state and key registers clear to 0.
  - rst mid-operation abandons the block with no output; rst overrides all other inputs.
- States: IDLE, ROUND, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid, the block captures state_reg <= plaintext ^ key and key_reg <= key, sets rnd_idx <= 1, and goes to ROUND.
  - in_ready=0 in all other states.
- ROUND:
  - rnd_state_o=state_reg, rnd_key_o=key_reg.
  - Each cycle: state_reg <= rnd_state_i, key_reg <= rnd_key_i.
  - If rnd_idx == NUM_ROUNDS: go to HOLD, set out_valid <= 1, pulse done. Otherwise rnd_idx <= rnd_idx+1.
  - rnd_idx never wraps past NUM_ROUNDS.
- HOLD:
  - ciphertext=state_reg; out_valid=1 and stable.
  - On out_ready: out_valid <= 0, rnd_idx <= 0, go to IDLE.
  - A new input is not accepted in the same cycle as out_ready; the earliest next accept is the following cycle.
- Latency: accept edge at cycle 0, out_valid high after NUM_ROUNDS+1 rising edges (11 by default).
- Throughput: one block per NUM_ROUNDS+2 cycles when out_ready is held high.
- Outside ROUND, rnd_state_o and rnd_key_o still reflect the registers, but rnd_idx=0 marks them don't-care.
- in_valid, plaintext and key are ignored outside IDLE; the captured values are never disturbed by input changes mid-block.
- out_ready is ignored outside HOLD.
- All XORs are full DATA_W; there is no truncation.

Optional Feature:
- Macro: CRYPT_BLOCK_COUNT_EN.
- When defined, the block adds output blk_count [31:0]:
  - reset to 0;
  - increments by 1 on every HOLD->IDLE transition (ciphertext accepted);
  - wraps 0xFFFFFFFF -> 0;
  - an aborted block (rst) does not count.
- When undefined, the port and its register are absent; all other behaviour is identical.

Test Plan:
- Stub round unit: rnd_state_i = rnd_state_o ^ rnd_key_o, rnd_key_i = rnd_key_o, with NUM_ROUNDS=10.
  - Stimulus: plaintext=128'h0123456789abcdeffedcba9876543210, key=128'h12121212121212121212121212121212.
  - Required: ciphertext=128'h133157759bb9dffdeccea88a64462002, out_valid 11 cycles after accept, done high exactly one cycle.
- Same stub with out_ready held low 20 cycles:
  - out_valid and ciphertext stay stable and done does not repeat;
  - a second in_valid is ignored (in_ready=0);
  - after out_ready, the next accept occurs 1 cycle later.
- Changing the stub key schedule to rnd_key_i = rnd_key_o + 1, with plaintext=0, key=1, NUM_ROUNDS=3:
  - ciphertext = 1^1^2^3 = 128'h1;
  - rnd_idx sequence is 1,2,3 and rnd_last is high only at 3.
- rst asserted in round 5:
  - next cycle IDLE, in_ready=1, out_valid=0, ciphertext=0;
  - a fresh block then encrypts correctly (same value as the first scenario).
- Back-to-back operation with in_valid and out_ready held high: two blocks complete with out_valid rising edges 12 cycles apart.
- With CRYPT_BLOCK_COUNT_EN: three accepted blocks plus one rst-aborted block give blk_count=3; rst clears it to 0.
